// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: row-major pixel scan sequencer for the bolometer mux; SCAN_TIMEOUT_EN adds an ADC watchdog
module matrix_scan_ctrl #(
  parameter int Width = 5,
  parameter int Rows = 2,
  parameter int Cols = 2,
  parameter int SettleCycles = 3,
  parameter int TimeoutCycles = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             adc_done_i,
  output logic             adc_start_o,
  output logic [Width-1:0] row_o,
  output logic [Width-1:0] col_o,
  output logic             row_en_o,
  output logic             col_en_o,
  output logic             pixel_valid_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             err_o
);
  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, ADVANCE} state_e;
  localparam int SW = $clog2(SettleCycles + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SettleCycles - 1);
  localparam logic [Width-1:0] ROW_LAST = Width'(Rows - 1);
  localparam logic [Width-1:0] COL_LAST = Width'(Cols - 1);
  state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [Width-1:0] row_q, row_d, col_q, col_d;
  logic adc_start_q, adc_start_d, row_en_q, row_en_d, col_en_q, col_en_d;
  logic pixel_valid_q, pixel_valid_d, frame_done_q, frame_done_d, busy_q, busy_d;
  logic last_col, last_px, timeout, enter_adv;
`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TimeoutCycles - 1);
  logic [TW-1:0] wd_q, wd_d;
  logic err_q, err_d;
  assign timeout = state_q == WAIT && !adc_done_i && wd_q == WD_LAST;
  assign wd_d = state_q == WAIT ? wd_q + TW'(1) : '0;
  assign err_d = timeout;
  assign err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o = TimeoutCycles < 0;
`endif
  always_comb begin
    last_col = col_q == COL_LAST;
    last_px = last_col && row_q == ROW_LAST;
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    settle_d = state_q == SETTLE ? settle_q + SW'(1) : '0;
    case (state_q)
      IDLE:    state_d = start_i ? SETTLE : IDLE;
      SETTLE:  state_d = settle_q == SETTLE_LAST ? CONV : SETTLE;
      CONV:    state_d = WAIT;
      WAIT:    state_d = adc_done_i || timeout ? ADVANCE : WAIT;
      ADVANCE: begin
        state_d = last_px ? IDLE : SETTLE;
        col_d = last_col ? '0 : col_q + Width'(1);
        row_d = last_px ? '0 : last_col ? row_q + Width'(1) : row_q;
      end
      default: state_d = IDLE;
    endcase
    enter_adv = state_q == WAIT && state_d == ADVANCE;
    adc_start_d = state_d == CONV;
    busy_d = state_d != IDLE;
    col_en_d = enter_adv;
    row_en_d = enter_adv && last_col;
    frame_done_d = enter_adv && last_px;
    pixel_valid_d = state_q == WAIT && adc_done_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      settle_q <= '0;
      row_q <= '0;
      col_q <= '0;
      adc_start_q <= 1'b0;
      row_en_q <= 1'b0;
      col_en_q <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      row_q <= row_d;
      col_q <= col_d;
      adc_start_q <= adc_start_d;
      row_en_q <= row_en_d;
      col_en_q <= col_en_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q <= frame_done_d;
      busy_q <= busy_d;
    end
  end
  assign adc_start_o = adc_start_q;
  assign row_o = row_q;
  assign col_o = col_q;
  assign row_en_o = row_en_q;
  assign col_en_o = col_en_q;
  assign pixel_valid_o = pixel_valid_q;
  assign frame_done_o = frame_done_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: scoreboard bench for matrix_scan_ctrl, 2x2 matrix, SettleCycles=3
module tb_matrix_scan_ctrl;
  typedef struct packed {
    logic [4:0] r;
    logic [4:0] c;
    logic ren;
    logic fd;
    logic err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, done = 1'b0;
  logic adc_start_o, row_en_o, col_en_o, pixel_valid_o, frame_done_o, busy_o, err_o;
  logic [4:0] row_o, col_o;
  int cyc = 0, n_chk = 0, n_fail = 0, fd_cnt = 0;
  exp_t sb[$];
  exp_t m_e;
  matrix_scan_ctrl #(
    .Width(5), .Rows(2), .Cols(2), .SettleCycles(3), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .adc_done_i(done),
    .adc_start_o(adc_start_o), .row_o(row_o), .col_o(col_o),
    .row_en_o(row_en_o), .col_en_o(col_en_o), .pixel_valid_o(pixel_valid_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [17:0] outs();
    return {adc_start_o, row_o, col_o, row_en_o, col_en_o, pixel_valid_o, frame_done_o, busy_o, err_o};
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done_o) fd_cnt++;
      if (col_en_o) begin
        if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else begin
          m_e = sb.pop_front();
          check("pix_row", row_o, m_e.r);
          check("pix_col", col_o, m_e.c);
          check("pix_row_en", row_en_o, m_e.ren);
          check("pix_frame_done", frame_done_o, m_e.fd);
          check("pix_err", err_o, m_e.err);
          check("pix_valid", pixel_valid_o, !m_e.err);
        end
      end else check("orphan_pulse", {pixel_valid_o, err_o, frame_done_o, row_en_o}, 0);
    end
  end
  task automatic push(input int r, input int c, input bit last, input bit err);
    exp_t e;
    e.r = 5'(r);
    e.c = 5'(c);
    e.ren = c == 1;
    e.fd = last;
    e.err = err;
    sb.push_back(e);
  endtask
  task automatic wait_adc(input bit spur, output int t);
    int n = 0;
    t = cyc;
    while (!adc_start_o && n < 100) begin
      done = spur;
      tick;
      n++;
    end
    if (!adc_start_o) check("adc_wait", adc_start_o, 1);
    t = cyc;
  endtask
  task automatic serve_pixel(input int r, input int c, input int delay, input bit spur, input bit last, output int t);
    push(r, c, last, 1'b0);
    wait_adc(spur, t);
    done = spur;
    tick;
    for (int i = 0; i < delay; i++) begin
      done = 1'b0;
      tick;
      check("pv_early", pixel_valid_o, 0);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    check("pv_lat", pixel_valid_o, 1);
  endtask
  task automatic run_frame(input int delay, input bit spur, input bit hold);
    int t0, t, prev;
    start = 1'b1;
    t0 = cyc;
    tick;
    if (!hold) start = 1'b0;
    check("busy_rise", busy_o, 1);
    prev = t0;
    for (int p = 0; p < 4; p++) begin
      serve_pixel(p / 2, p % 2, delay, spur, p == 3, t);
      if (p == 0) check("adc_lat", t - prev, 4);
      else check("px_period", t - prev, 6 + delay);
      prev = t;
    end
    tick;
    check("busy_fall", busy_o, 0);
  endtask
  initial begin
    int t;
    int fdc;
    rst = 1'b1;
    start = 1'b1;
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_outs", outs(), 0);
    end
    rst = 1'b0;
    start = 1'b0;
    done = 1'b0;
    check("post_rst_outs", outs(), 0);
    tick;
    check("idle_outs", outs(), 0);
    run_frame(0, 1'b0, 1'b0);
`ifdef SCAN_TIMEOUT_EN
    run_frame(7, 1'b1, 1'b0);
`else
    run_frame(10, 1'b1, 1'b0);
`endif
    run_frame(0, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b1);
    start = 1'b0;
    tick;
    check("idle_after_hold", busy_o, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int p = 0; p < 2; p++) serve_pixel(0, p, 0, 1'b0, 1'b0, t);
    wait_adc(1'b0, t);
    tick;
    rst = 1'b1;
    fdc = fd_cnt;
    tick;
    rst = 1'b0;
    check("abort_outs", outs(), 0);
    repeat (10) tick;
    check("abort_no_fd", fd_cnt, fdc);
    check("abort_idle", busy_o, 0);
`ifdef SCAN_TIMEOUT_EN
    fdc = fd_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push(p / 2, p % 2, p == 3, 1'b1);
      wait_adc(1'b0, t);
      tick;
      for (int i = 0; i < 8; i++) begin
        check("err_early", {err_o, pixel_valid_o}, 0);
        tick;
      end
      check("err_pulse", {err_o, pixel_valid_o}, 2'b10);
    end
    tick;
    check("to_fd", fd_cnt, fdc + 1);
    check("to_idle", busy_o, 0);
`else
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_adc(1'b0, t);
    tick;
    repeat (30) begin
      check("wait_hold", {busy_o, err_o, pixel_valid_o}, 3'b100);
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
`endif
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
